// File: rtl/nfc_rng_ctrl_pkg.sv
// Shared types and constants for the NFC RNG stream controller.
// Holds the FSM encoding, RNG mode codes and the captured job configuration.
package nfc_rng_ctrl_pkg;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned SEED_W = 32;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned DAT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [MODE_W-1:0] RNG_LFSR = 2'b00;
  localparam logic [MODE_W-1:0] RNG_HOLD = 2'b01;
  localparam logic [MODE_W-1:0] RNG_INC  = 2'b10;
  localparam logic [MODE_W-1:0] RNG_DEC  = 2'b11;

  typedef struct packed {
    logic [SEED_W-1:0] seed;
    logic [MODE_W-1:0] mode;
  } rng_cfg_t;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/nfc_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the channel preferred next.
module nfc_rr_arb2
  import nfc_rng_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              take,
  output logic [NUM_CH-1:0] grant,
  output logic              win
);

  logic ptr;

  always_comb begin
    win = ptr;
    if (!req[ptr]) win = ~ptr;
    grant = (|req) ? ch_onehot(win) : '0;
  end

  // After a grant the other channel gets priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (take && (|req)) begin
      ptr <= ~win;
    end
  end

endmodule

// File: rtl/nfc_rng_ctrl.sv
// Arbitrates two requesters onto an external byte RNG and streams one job of
// RNG bytes to the granted requester with a seed/run/gap sequence per job.
module nfc_rng_ctrl
  import nfc_rng_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     req,
  input  logic [2*SEED_W-1:0]   req_seed,
  input  logic [2*MODE_W-1:0]   req_mode,
  input  logic [2*LEN_W-1:0]    req_len,
  output logic [NUM_CH-1:0]     gnt,
  output logic [NUM_CH-1:0]     done,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DAT_W-1:0]      out_dat,
  output logic                  out_last,
  output logic                  rng_en,
  output logic                  rng_rd,
  output logic [SEED_W-1:0]     rng_seed,
  output logic [MODE_W-1:0]     rng_mode,
  input  logic [DAT_W-1:0]      rng_dat
);

  localparam int unsigned CNT_W = LEN_W + 1;

  state_t            state, state_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [NUM_CH-1:0] gnt_n, done_n;
  rng_cfg_t          cfg_q, cfg_n, cfg_sel;
  logic [LEN_W-1:0]  len_sel;
  logic [NUM_CH-1:0] arb_grant;
  logic              arb_win;
  logic              arb_take;
  logic              job_live;

  nfc_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .take  (arb_take),
    .grant (arb_grant),
    .win   (arb_win)
  );

  always_comb begin
    cfg_sel.seed = arb_win ? req_seed[2*SEED_W-1:SEED_W] : req_seed[SEED_W-1:0];
    cfg_sel.mode = arb_win ? req_mode[2*MODE_W-1:MODE_W] : req_mode[MODE_W-1:0];
    len_sel      = arb_win ? req_len[2*LEN_W-1:LEN_W]    : req_len[LEN_W-1:0];
  end

  assign job_live = |(req & gnt);
  assign rng_seed = cfg_q.seed;
  assign rng_mode = cfg_q.mode;
  assign out_dat  = out_vld ? rng_dat : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= '0;
      done  <= '0;
      count <= '0;
      cfg_q <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      done  <= done_n;
      count <= count_n;
      cfg_q <= cfg_n;
    end
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    done_n   = '0;
    count_n  = count;
    cfg_n    = cfg_q;
    arb_take = 1'b0;
    out_vld  = 1'b0;
    out_last = 1'b0;
    rng_en   = 1'b0;
    rng_rd   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (|req) begin
          arb_take = 1'b1;
          gnt_n    = arb_grant;
          cfg_n    = cfg_sel;
          // A zero length encodes the full 2^LEN_W byte job.
          count_n  = {(len_sel == '0), len_sel};
          state_n  = ST_SEED;
        end
      end

      ST_SEED: begin
        rng_en = 1'b1;
        if (!job_live) begin
          done_n  = gnt;
          gnt_n   = '0;
          count_n = '0;
          state_n = ST_GAP;
        end else begin
          state_n = ST_RUN;
        end
      end

      ST_RUN: begin
        rng_en = 1'b1;
        if (!job_live) begin
          done_n  = gnt;
          gnt_n   = '0;
          count_n = '0;
          state_n = ST_GAP;
        end else begin
          out_vld  = 1'b1;
          out_last = (count == CNT_W'(1));
          rng_rd   = out_vld & out_rdy;
          if (rng_rd) begin
            count_n = count - CNT_W'(1);
            if (out_last) begin
              done_n  = gnt;
              gnt_n   = '0;
              state_n = ST_GAP;
            end
          end
        end
      end

      ST_GAP: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nfc_rng_ctrl.sv
// Directed bench for nfc_rng_ctrl with a behavioural byte RNG attached.
module tb_nfc_rng_ctrl;

  localparam int unsigned LEN_W = 12;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req;
  logic [63:0]        req_seed;
  logic [3:0]         req_mode;
  logic [2*LEN_W-1:0] req_len;
  logic [1:0]         gnt, done;
  logic               out_vld, out_rdy, out_last;
  logic [7:0]         out_dat;
  logic               rng_en, rng_rd;
  logic [31:0]        rng_seed;
  logic [1:0]         rng_mode;
  logic [7:0]         rng_dat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nfc_rng_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_seed(req_seed), .req_mode(req_mode),
    .req_len(req_len), .gnt(gnt), .done(done), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_dat(out_dat), .out_last(out_last), .rng_en(rng_en), .rng_rd(rng_rd),
    .rng_seed(rng_seed), .rng_mode(rng_mode), .rng_dat(rng_dat)
  );

  function automatic logic [31:0] rng_step(input logic [31:0] s, input logic [1:0] m);
    case (m)
      2'b00:   return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
      2'b10:   return {s[31:24] + 8'd1, s[23:0]};
      2'b11:   return {s[31:24] - 8'd1, s[23:0]};
      default: return s;
    endcase
  endfunction

  // Byte RNG: loads the seed on an en rising edge, steps on each read.
  logic [31:0] rng_st;
  logic        en_q;
  always_ff @(posedge clk) begin
    en_q <= rng_en;
    if (rng_en && !en_q) rng_st <= rng_seed;
    else if (rng_en && rng_rd) rng_st <= rng_step(rng_st, rng_mode);
  end
  assign rng_dat = rng_st[31:24];

  logic [7:0] byte_q[$];
  bit         last_q[$];
  int rd_cnt, d0, d1, rd_err, hold_err;
  bit tog, scramble;

  task automatic observe(input int ncyc);
    logic [7:0] prev_dat;
    bit prev_stall;
    byte_q.delete(); last_q.delete();
    rd_cnt = 0; d0 = 0; d1 = 0; rd_err = 0; hold_err = 0;
    prev_stall = 0; prev_dat = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (tog) out_rdy = ~out_rdy;
      if (scramble && i == 1) begin
        req_seed = ~req_seed; req_mode = ~req_mode; req_len = '1;
      end
      #1;
      if (rng_rd !== (out_vld & out_rdy)) rd_err++;
      if (prev_stall && out_vld && (out_dat !== prev_dat)) hold_err++;
      prev_stall = out_vld && !out_rdy;
      prev_dat = out_dat;
      if (rng_rd) begin byte_q.push_back(out_dat); last_q.push_back(out_last); rd_cnt++; end
      if (done[0]) d0++;
      if (done[1]) d1++;
      if (|done) req = 2'b00;
    end
  endtask

  task automatic test_reset();
    rst = 1; req = 0; req_seed = '0; req_mode = '0; req_len = '0; out_rdy = 0;
    tog = 0; scramble = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (gnt !== 2'b00 || done !== 2'b00) begin failures++; $display("FAIL reset_gnt_done got=%0h/%0h exp=0/0", gnt, done); end
    checks++; if ({out_vld, out_last, rng_en, rng_rd} !== 4'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=0000", {out_vld, out_last, rng_en, rng_rd}); end
    checks++; if (rng_seed !== 32'h0 || rng_mode !== 2'b00) begin failures++; $display("FAIL reset_cfg got=%0h/%0h exp=0/0", rng_seed, rng_mode); end
    checks++; if (out_dat !== 8'h00) begin failures++; $display("FAIL reset_dat got=%0h exp=0", out_dat); end
    rst = 0;
  endtask

  task automatic test_inc();
    req_seed = {32'hDEAD0000, 32'h05000000}; req_mode = 4'b0010;
    req_len = {12'd9, 12'd3}; out_rdy = 1; req = 2'b01;
    observe(12);
    checks++; if (rd_cnt !== 3) begin failures++; $display("FAIL inc_count got=%0d exp=3", rd_cnt); end
    if (rd_cnt == 3) begin
      checks++; if (byte_q[0] !== 8'h05 || byte_q[1] !== 8'h06 || byte_q[2] !== 8'h07) begin
        failures++; $display("FAIL inc_bytes got=%0h %0h %0h exp=5 6 7", byte_q[0], byte_q[1], byte_q[2]); end
      checks++; if ({last_q[0], last_q[1], last_q[2]} !== 3'b001) begin
        failures++; $display("FAIL inc_last got=%b exp=001", {last_q[0], last_q[1], last_q[2]}); end
    end
    checks++; if (d0 !== 1 || d1 !== 0) begin failures++; $display("FAIL inc_done got=%0d/%0d exp=1/0", d0, d1); end
    checks++; if (rd_err !== 0) begin failures++; $display("FAIL inc_rd got=%0d exp=0", rd_err); end
  endtask

  task automatic test_lfsr();
    logic [31:0] e;
    req_seed = {32'h0, 32'h12345678}; req_mode = 4'b0000;
    req_len = {12'd1, 12'd8}; out_rdy = 1; req = 2'b01;
    observe(16);
    checks++; if (rd_cnt !== 8) begin failures++; $display("FAIL lfsr_count got=%0d exp=8", rd_cnt); end
    if (rd_cnt == 8) begin
      checks++; if (byte_q[0] !== 8'h12) begin failures++; $display("FAIL lfsr_first got=%0h exp=12", byte_q[0]); end
      e = 32'h12345678;
      for (int i = 0; i < 8; i++) begin
        checks++; if (byte_q[i] !== e[31:24] || last_q[i] !== (i == 7)) begin
          failures++; $display("FAIL lfsr_byte%0d got=%0h/%0b exp=%0h/%0b", i, byte_q[i], last_q[i], e[31:24], i == 7); end
        e = rng_step(e, 2'b00);
      end
    end
    checks++; if (d0 !== 1) begin failures++; $display("FAIL lfsr_done got=%0d exp=1", d0); end
  endtask

  task automatic test_round_robin();
    logic [1:0] gq[$];
    int gaps[$];
    logic [1:0] prev_gnt;
    int low, nd0, nd1;
    bit seen_en;
    logic [7:0] exp_b[6];
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    req_seed = {32'h20000000, 32'h10000000}; req_mode = 4'b1110;
    req_len = {12'd2, 12'd2}; out_rdy = 1; req = 2'b11;
    byte_q.delete(); prev_gnt = 0; low = 0; seen_en = 0; nd0 = 0; nd1 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (gnt != 2'b00 && gnt != prev_gnt) gq.push_back(gnt);
      prev_gnt = gnt;
      if (rng_rd) byte_q.push_back(out_dat);
      if (!rng_en) low++;
      else begin
        if (seen_en && low > 0) gaps.push_back(low);
        low = 0; seen_en = 1;
      end
      if (done[0]) nd0++;
      if (done[1]) nd1++;
      if (nd0 + nd1 == 3) begin req = 2'b00; break; end
    end
    checks++; if (gq.size() !== 3) begin failures++; $display("FAIL rr_grants got=%0d exp=3", gq.size()); end
    if (gq.size() == 3) begin
      checks++; if (gq[0] !== 2'b01 || gq[1] !== 2'b10 || gq[2] !== 2'b01) begin
        failures++; $display("FAIL rr_order got=%0h %0h %0h exp=1 2 1", gq[0], gq[1], gq[2]); end
    end
    checks++; if (nd0 !== 2 || nd1 !== 1) begin failures++; $display("FAIL rr_done got=%0d/%0d exp=2/1", nd0, nd1); end
    // rng_en is low for the GAP cycle plus the following arbitration cycle.
    checks++; if (gaps.size() !== 2) begin failures++; $display("FAIL rr_gapcnt got=%0d exp=2", gaps.size()); end
    else begin
      checks++; if (gaps[0] !== 2 || gaps[1] !== 2) begin failures++; $display("FAIL rr_gaplen got=%0d %0d exp=2 2", gaps[0], gaps[1]); end
    end
    exp_b = '{8'h10, 8'h11, 8'h20, 8'h1F, 8'h10, 8'h11};
    checks++; if (byte_q.size() !== 6) begin failures++; $display("FAIL rr_bytes got=%0d exp=6", byte_q.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (byte_q[i] !== exp_b[i]) begin failures++; $display("FAIL rr_byte%0d got=%0h exp=%0h", i, byte_q[i], exp_b[i]); end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    req_seed = {32'h0, 32'h40000000}; req_mode = 4'b0010;
    req_len = {12'd0, 12'd4}; out_rdy = 1; req = 2'b01;
    tog = 1; scramble = 1;
    observe(24);
    tog = 0; scramble = 0; out_rdy = 1;
    checks++; if (rd_cnt !== 4) begin failures++; $display("FAIL bp_rd got=%0d exp=4", rd_cnt); end
    if (rd_cnt == 4) begin
      checks++; if (byte_q[0] !== 8'h40 || byte_q[1] !== 8'h41 || byte_q[2] !== 8'h42 || byte_q[3] !== 8'h43) begin
        failures++; $display("FAIL bp_bytes got=%0h %0h %0h %0h exp=40 41 42 43", byte_q[0], byte_q[1], byte_q[2], byte_q[3]); end
    end
    checks++; if (hold_err !== 0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", hold_err); end
    checks++; if (rd_err !== 0) begin failures++; $display("FAIL bp_rdrule got=%0d exp=0", rd_err); end
    checks++; if (d0 !== 1) begin failures++; $display("FAIL bp_done got=%0d exp=1", d0); end
  endtask

  task automatic test_abort();
    int rds, nd;
    bit chk_next;
    logic [2:0] at_done, after_done;
    req_seed = {32'h0, 32'h00000000}; req_mode = 4'b0010;
    req_len = {12'd0, 12'd10}; out_rdy = 1; req = 2'b01;
    rds = 0; nd = 0; chk_next = 0; at_done = 3'b111; after_done = 3'b111;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rds >= 2) req = 2'b00;
      #1;
      if (rng_rd) rds++;
      if (chk_next) begin after_done = {rng_en, out_vld, |done}; chk_next = 0; end
      if (done[0]) begin nd++; at_done = {rng_en, out_vld, |gnt}; chk_next = 1; end
    end
    checks++; if (rds !== 2) begin failures++; $display("FAIL abort_rd got=%0d exp=2", rds); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL abort_done got=%0d exp=1", nd); end
    checks++; if (at_done !== 3'b000) begin failures++; $display("FAIL abort_gap got=%b exp=000", at_done); end
    checks++; if (after_done !== 3'b000) begin failures++; $display("FAIL abort_idle got=%b exp=000", after_done); end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    req_seed = {32'h77000000, 32'h0}; req_mode = 4'b0100;
    req_len = {12'd10, 12'd0}; out_rdy = 1; req = 2'b10;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #1;
      if (out_vld) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL midrst_start got=0 exp=1"); end
    rst = 1;
    @(negedge clk); #1;
    checks++; if ({gnt, done, out_vld, out_last, rng_en, rng_rd} !== 8'h00) begin
      failures++; $display("FAIL midrst_ctl got=%b exp=00000000", {gnt, done, out_vld, out_last, rng_en, rng_rd}); end
    checks++; if (rng_seed !== 32'h0 || rng_mode !== 2'b00) begin
      failures++; $display("FAIL midrst_cfg got=%0h/%0h exp=0/0", rng_seed, rng_mode); end
    rst = 0;
    @(negedge clk); #1;
    checks++; if (gnt !== 2'b10 || rng_en !== 1'b1 || out_vld !== 1'b0 || rng_seed !== 32'h77000000 || rng_mode !== 2'b01) begin
      failures++; $display("FAIL midrst_seed got=%0h/%b/%b/%0h/%0h exp=2/1/0/77000000/1", gnt, rng_en, out_vld, rng_seed, rng_mode); end
    @(negedge clk); #1;
    checks++; if (out_vld !== 1'b1 || out_dat !== 8'h77) begin
      failures++; $display("FAIL midrst_run got=%b/%0h exp=1/77", out_vld, out_dat); end
    req = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_len_zero();
    int last_idx, nlast;
    req_seed = {32'h0, 32'hAB000000}; req_mode = 4'b0001;
    req_len = {12'd5, 12'd0}; out_rdy = 1; req = 2'b01;
    observe(4110);
    last_idx = -1; nlast = 0;
    foreach (last_q[i]) if (last_q[i]) begin nlast++; last_idx = i; end
    checks++; if (rd_cnt !== 4096) begin failures++; $display("FAIL len0_count got=%0d exp=4096", rd_cnt); end
    checks++; if (nlast !== 1 || last_idx !== 4095) begin failures++; $display("FAIL len0_last got=%0d@%0d exp=1@4095", nlast, last_idx); end
    checks++; if (d0 !== 1) begin failures++; $display("FAIL len0_done got=%0d exp=1", d0); end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_lfsr();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_reset_mid_run();
    test_len_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
